// File: rtl/cfeb_link_qualifier.sv
// ============================================================================
// cfeb_link_qualifier : qualifies one DCFEB optical link and gates its comparator data
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cfeb_link_qualifier #(
  parameter int QUAL_BX    = 1024,
  parameter int ERR_WINDOW = 4096,
  parameter int ERR_THRESH = 4,
  parameter int HOLDOFF_BX = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ttc_resync,
  input  logic        gtx_rx_sync_done,
  input  logic        gtx_rx_valid,
  input  logic        link_good,
  input  logic        link_bad,
  input  logic [47:0] gtx_rx_data,
  input  logic        cfeb_mask,
  input  logic        force_pass,
  output logic [47:0] cfeb_data,
  output logic        link_qualified,
  output logic [1:0]  link_state,
  output logic [7:0]  drop_count,
  output logic [15:0] err_total,
  output logic [7:0]  win_err_count
);

  localparam int QW = (QUAL_BX    > 1) ? $clog2(QUAL_BX)    : 1;
  localparam int WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int HW = (HOLDOFF_BX > 1) ? $clog2(HOLDOFF_BX) : 1;

  localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_BX - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_BX - 1);
  localparam logic [8:0]    THRESH9   = 9'(ERR_THRESH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    GOOD    = 2'd2,
    PENALTY = 2'd3
  } state_t;

  state_t        state;
  logic [QW-1:0] qual_cnt;
  logic [WW-1:0] win_cnt;
  logic [HW-1:0] hold_cnt;
  logic [7:0]    win_err;

  logic err_now;
  logic win_wrap;
  logic thresh_hit;
  logic drop_event;
  logic pass_data;

  assign err_now    = gtx_rx_sync_done & (~gtx_rx_valid | ~link_good | link_bad);
  assign win_wrap   = (win_cnt == WIN_LAST);
  assign thresh_hit = err_now && (({1'b0, win_err} + 9'd1) >= THRESH9);
  // Losing sync and hitting the threshold on the same cycle is one drop, not two.
  assign drop_event = (state == GOOD) && (!gtx_rx_sync_done || thresh_hit);
  assign pass_data  = !cfeb_mask && (((state == GOOD) && !err_now) || force_pass);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      qual_cnt <= '0;
      win_cnt  <= '0;
      hold_cnt <= '0;
      win_err  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gtx_rx_sync_done) begin
            state    <= QUAL;
            qual_cnt <= '0;
          end
        end
        QUAL: begin
          if (!gtx_rx_sync_done) begin
            state <= IDLE;
          end else if (err_now) begin
            qual_cnt <= '0;
          end else if (qual_cnt == QUAL_LAST) begin
            state   <= GOOD;
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            qual_cnt <= qual_cnt + 1'b1;
          end
        end
        GOOD: begin
          if (!gtx_rx_sync_done) begin
            state <= IDLE;
          end else if (thresh_hit) begin
            state    <= PENALTY;
            hold_cnt <= '0;
          end else if (win_wrap) begin
            // An error on the wrap cycle belongs to the closing window.
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            if (err_now) begin
              win_err <= win_err + 8'd1;
            end
          end
        end
        PENALTY: begin
          if (!gtx_rx_sync_done) begin
            state <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= QUAL;
            qual_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_total  <= '0;
      drop_count <= '0;
    end else if (ttc_resync) begin
      err_total  <= '0;
      drop_count <= '0;
    end else begin
      if (err_now && (err_total != 16'hFFFF)) begin
        err_total <= err_total + 16'd1;
      end
      if (drop_event && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfeb_data <= '0;
    end else begin
      cfeb_data <= pass_data ? gtx_rx_data : 48'd0;
    end
  end

  assign link_state     = state;
  assign link_qualified = (state == GOOD);
  assign win_err_count  = (state == GOOD) ? win_err : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_cfeb_link_qualifier.sv
// ============================================================================
// tb_cfeb_link_qualifier : directed checks of link qualification and data gating
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cfeb_link_qualifier;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ttc_resync;
  logic        gtx_rx_sync_done;
  logic        gtx_rx_valid;
  logic        link_good;
  logic        link_bad;
  logic [47:0] gtx_rx_data;
  logic        cfeb_mask;
  logic        force_pass;
  logic [47:0] cfeb_data;
  logic        link_qualified;
  logic [1:0]  link_state;
  logic [7:0]  drop_count;
  logic [15:0] err_total;
  logic [7:0]  win_err_count;

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] PAT_A = 48'hA5A5_A5A5_A5A5;
  localparam logic [47:0] PAT_B = 48'h1234_5678_9ABC;

  cfeb_link_qualifier #(
    .QUAL_BX   (8),
    .ERR_WINDOW(16),
    .ERR_THRESH(3),
    .HOLDOFF_BX(4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ttc_resync      (ttc_resync),
    .gtx_rx_sync_done(gtx_rx_sync_done),
    .gtx_rx_valid    (gtx_rx_valid),
    .link_good       (link_good),
    .link_bad        (link_bad),
    .gtx_rx_data     (gtx_rx_data),
    .cfeb_mask       (cfeb_mask),
    .force_pass      (force_pass),
    .cfeb_data       (cfeb_data),
    .link_qualified  (link_qualified),
    .link_state      (link_state),
    .drop_count      (drop_count),
    .err_total       (err_total),
    .win_err_count   (win_err_count)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    ttc_resync       = 1'b0;
    gtx_rx_sync_done = 1'b0;
    gtx_rx_valid     = 1'b1;
    link_good        = 1'b1;
    link_bad         = 1'b0;
    gtx_rx_data      = PAT_A;
    cfeb_mask        = 1'b0;
    force_pass       = 1'b0;
    tick(3);
    chk("rst_state", 48'(link_state), 48'd0);
    chk("rst_qual", 48'(link_qualified), 48'd0);
    chk("rst_data", cfeb_data, 48'd0);
    chk("rst_drop", 48'(drop_count), 48'd0);
    chk("rst_errtot", 48'(err_total), 48'd0);
    chk("rst_winerr", 48'(win_err_count), 48'd0);

    // Qualification from reset
    reset_n          = 1'b1;
    gtx_rx_sync_done = 1'b1;
    tick(1);
    chk("s1_qual_entry", 48'(link_state), 48'd1);
    tick(7);
    chk("s1_still_qual", 48'(link_state), 48'd1);
    chk("s1_data_gated", cfeb_data, 48'd0);
    tick(1);
    chk("s1_good", 48'(link_state), 48'd2);
    chk("s1_qualified", 48'(link_qualified), 48'd1);
    chk("s1_data_lag", cfeb_data, 48'd0);
    tick(1);
    chk("s1_data_pass", cfeb_data, PAT_A);

    // Three errors at window offsets 2, 7, 11 (window counter is 1 here)
    tick(1);
    link_bad = 1'b1; tick(1); link_bad = 1'b0;
    chk("s3_win1", 48'(win_err_count), 48'd1);
    tick(4);
    link_bad = 1'b1; tick(1); link_bad = 1'b0;
    chk("s3_win2", 48'(win_err_count), 48'd2);
    tick(3);
    chk("s3_data_before", cfeb_data, PAT_A);
    link_bad = 1'b1; tick(1); link_bad = 1'b0;
    chk("s3_penalty", 48'(link_state), 48'd3);
    chk("s3_drop", 48'(drop_count), 48'd1);
    chk("s3_data_zero", cfeb_data, 48'd0);
    chk("s3_errtot", 48'(err_total), 48'd3);
    chk("s3_winerr_out", 48'(win_err_count), 48'd0);
    tick(3);
    chk("s3_hold", 48'(link_state), 48'd3);
    tick(1);
    chk("s3_requal", 48'(link_state), 48'd1);

    // Clean run broken by a valid dropout after 5 cycles
    tick(5);
    gtx_rx_valid = 1'b0; tick(1); gtx_rx_valid = 1'b1;
    chk("s2_errtot", 48'(err_total), 48'd4);
    tick(7);
    chk("s2_not_yet", 48'(link_state), 48'd1);
    tick(1);
    chk("s2_good", 48'(link_state), 48'd2);

    // Errors at offsets 14, 15 then offset 1 of the next window
    tick(14);
    link_bad = 1'b1; tick(2); link_bad = 1'b0;
    chk("s4_wrap_state", 48'(link_state), 48'd2);
    chk("s4_wrap_clear", 48'(win_err_count), 48'd0);
    tick(1);
    link_bad = 1'b1; tick(1); link_bad = 1'b0;
    chk("s4_state", 48'(link_state), 48'd2);
    chk("s4_winerr", 48'(win_err_count), 48'd1);
    chk("s4_errtot", 48'(err_total), 48'd7);

    // One more error then sync loss together with link_bad
    link_bad = 1'b1; tick(1);
    chk("s5_winerr2", 48'(win_err_count), 48'd2);
    gtx_rx_sync_done = 1'b0; tick(1); link_bad = 1'b0;
    chk("s5_idle", 48'(link_state), 48'd0);
    chk("s5_drop", 48'(drop_count), 48'd2);
    chk("s5_errtot", 48'(err_total), 48'd8);
    chk("s5_data_last", cfeb_data, PAT_A);

    // force_pass bypasses qualification
    gtx_rx_data = PAT_B;
    force_pass  = 1'b1; tick(1);
    chk("fp_idle_pass", cfeb_data, PAT_B);
    chk("fp_state", 48'(link_state), 48'd0);
    force_pass  = 1'b0; tick(1);
    chk("fp_off", cfeb_data, 48'd0);

    gtx_rx_sync_done = 1'b1;
    tick(9);
    chk("s6_good", 48'(link_state), 48'd2);

    // Mask overrides force_pass
    cfeb_mask = 1'b1; force_pass = 1'b1; tick(1);
    chk("s6_mask", cfeb_data, 48'd0);
    cfeb_mask = 1'b0; force_pass = 1'b0; tick(1);
    chk("s6_unmask", cfeb_data, PAT_B);

    // Resync clears stats and discards a coincident error increment
    ttc_resync = 1'b1; link_bad = 1'b1; tick(1);
    ttc_resync = 1'b0;
    chk("s6_resync_err", 48'(err_total), 48'd0);
    chk("s6_resync_drop", 48'(drop_count), 48'd0);
    chk("s6_resync_state", 48'(link_state), 48'd2);
    chk("s6_resync_win", 48'(win_err_count), 48'd1);
    tick(2); link_bad = 1'b0;
    chk("s6_penalty", 48'(link_state), 48'd3);
    chk("s6_drop", 48'(drop_count), 48'd1);
    chk("s6_errtot", 48'(err_total), 48'd2);

    // Asynchronous reset in PENALTY
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_state", 48'(link_state), 48'd0);
    chk("ar_data", cfeb_data, 48'd0);
    chk("ar_drop", 48'(drop_count), 48'd0);
    chk("ar_errtot", 48'(err_total), 48'd0);
    chk("ar_qual", 48'(link_qualified), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
